// File: rtl/sprite_pkg.sv
// Shared constants for the sprite pipeline: ROM geometry, sprite IDs,
// facing directions and the line renderer state encoding.
package sprite_pkg;

    localparam int SPRITE_ROWS = 8;

    localparam logic [1:0] UP    = 2'd0;
    localparam logic [1:0] RIGHT = 2'd1;
    localparam logic [1:0] DOWN  = 2'd2;
    localparam logic [1:0] LEFT  = 2'd3;

    localparam logic [3:0] HEART       = 4'd0;
    localparam logic [3:0] SWORD       = 4'd1;
    localparam logic [3:0] GNOME_1     = 4'd2;
    localparam logic [3:0] GNOME_2     = 4'd3;
    localparam logic [3:0] DRAGON_2    = 4'd4;
    localparam logic [3:0] DRAGON_3    = 4'd5;
    localparam logic [3:0] DRAGON_HEAD = 4'd6;
    localparam logic [3:0] SHEEP_1     = 4'd7;
    localparam logic [3:0] SHEEP_2     = 4'd8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        ARMED = 3'd3,
        DRAW  = 3'd4
    } state_t;

endpackage

// File: rtl/sprite_row_shifter.sv
// Holds one fetched sprite row and serialises it, each ROM bit stretched
// over 2^SCALE_LOG2 enabled pixels; bit 7 is the leftmost pixel, 0 = opaque.
module sprite_row_shifter
    import sprite_pkg::*;
#(
    parameter int SCALE_LOG2 = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_pix_en,
    input  logic       i_load,
    input  logic [7:0] i_row,
    input  logic       i_advance,
    output logic       o_last,
    output logic       o_pixel_on
);

    localparam int CW = 3 + SCALE_LOG2;

    logic [7:0]    r_row_buf;
    logic [CW-1:0] r_count;
    logic          r_pixel_on;
    logic [2:0]    w_bit_idx;
    logic [2:0]    w_bit_sel;
    logic          w_bit;

    assign w_bit_idx  = 3'(r_count >> SCALE_LOG2);
    assign w_bit_sel  = 3'(SPRITE_ROWS - 1) - w_bit_idx;
    assign w_bit      = r_row_buf[w_bit_sel];
    assign o_last     = &r_count;
    assign o_pixel_on = r_pixel_on;

    // NOTE: sequential state uses non-blocking assignments and resets asynchronously, so every register here has a defined value the instant reset drops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_row_buf <= 8'hFF;
            r_count   <= '0;
        end else if (i_load) begin
            r_row_buf <= i_row;
            r_count   <= '0;
        end else if (i_advance) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Any enabled pixel that is not part of the sprite span clears the flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pixel_on <= 1'b0;
        end else if (i_pix_en) begin
            r_pixel_on <= i_advance ? ~w_bit : 1'b0;
        end
    end

endmodule

// File: rtl/sprite_line_renderer.sv
// Per-scanline sprite slot: decides whether the sprite covers the coming line,
// addresses the ROM row, then emits an opaque flag per pixel from sprite_x on.
module sprite_line_renderer
    import sprite_pkg::*;
#(
    parameter int SCALE_LOG2 = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_en,
    input  logic [9:0] pix_x,
    input  logic       line_start,
    input  logic [9:0] line_y,
    input  logic       enable,
    input  logic [9:0] sprite_x,
    input  logic [9:0] sprite_y,
    input  logic [3:0] charc,
    input  logic [1:0] direction,
    output logic [3:0] rom_charc,
    output logic [1:0] rom_direction,
    output logic [2:0] rom_index,
    input  logic [7:0] rom_data,
    output logic       pixel_on,
    output logic       busy
);

    state_t     r_state;
    state_t     w_next_state;
    logic [9:0] w_dy;
    logic [2:0] w_row;
    logic       w_in_range;
    logic       w_capture;
    logic       w_hit;
    logic       w_load;
    logic       w_advance;
    logic       w_last;
    logic [9:0] r_sprite_x;
    logic [3:0] r_rom_charc;
    logic [1:0] r_rom_direction;
    logic [2:0] r_rom_index;

    assign w_dy       = line_y - sprite_y;
    assign w_in_range = enable && (line_y >= sprite_y)
                        && ((w_dy >> SCALE_LOG2) < 10'(SPRITE_ROWS));
    assign w_row      = 3'(w_dy >> SCALE_LOG2);
    assign w_capture  = line_start && w_in_range;
    assign w_hit      = pix_en && (pix_x == r_sprite_x);

    assign rom_charc     = r_rom_charc;
    assign rom_direction = r_rom_direction;
    assign rom_index     = r_rom_index;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    // line_start wins in every state, so a late line aborts whatever is in flight.
    always_comb begin
        // NOTE: default assignment first so no path leaves the signal unassigned and infers a latch.
        w_next_state = r_state;
        if (line_start) begin
            w_next_state = w_in_range ? FETCH : IDLE;
        end else begin
            case (r_state)
                FETCH:   w_next_state = LOAD;
                LOAD:    w_next_state = ARMED;
                ARMED:   if (w_hit) w_next_state = DRAW;
                DRAW:    if (pix_en && w_last) w_next_state = IDLE;
                default: w_next_state = r_state;
            endcase
        end
    end

    always_comb begin
        w_load    = 1'b0;
        w_advance = 1'b0;
        busy      = (r_state != IDLE);
        if (!line_start) begin
            w_load    = (r_state == LOAD);
            w_advance = ((r_state == ARMED) && w_hit) || ((r_state == DRAW) && pix_en);
        end
    end

    // Slot attributes are snapshotted here; mid-line edits wait for the next line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sprite_x      <= '0;
            r_rom_charc     <= '0;
            r_rom_direction <= '0;
            r_rom_index     <= '0;
        end else if (w_capture) begin
            r_sprite_x      <= sprite_x;
            r_rom_charc     <= charc;
            r_rom_direction <= direction;
            r_rom_index     <= w_row;
        end
    end

    sprite_row_shifter #(
        .SCALE_LOG2 (SCALE_LOG2)
    ) u_shifter (
        .clk        (clk),
        .reset      (reset),
        .i_pix_en   (pix_en),
        .i_load     (w_load),
        .i_row      (rom_data),
        .i_advance  (w_advance),
        .o_last     (w_last),
        .o_pixel_on (pixel_on)
    );

endmodule

// File: tb/tb_sprite_line_renderer.sv
// Drives a 1x and a 2x renderer from the same slot/timing inputs and checks
// ROM addressing and per-pixel opacity against a line-level reference model.
module tb_sprite_line_renderer;
    import sprite_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       pix_en;
    logic [9:0] pix_x;
    logic       line_start;
    logic [9:0] line_y;
    logic       enable;
    logic [9:0] sprite_x;
    logic [9:0] sprite_y;
    logic [3:0] charc;
    logic [1:0] direction;

    logic [3:0] rc    [2];
    logic [1:0] rd    [2];
    logic [2:0] ri    [2];
    logic [7:0] rdata [2];
    logic       pon   [2];
    logic       bsy   [2];

    logic [7:0] rom [16][4][8];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: expected line snapshot per instance (index = SCALE_LOG2)
    bit         m_inr [2];
    int         m_sx  [2];
    logic [7:0] m_row [2];
    logic [2:0] m_idx [2];
    logic [3:0] m_chr [2];
    logic [1:0] m_dir [2];

    always #5 clk = ~clk;

    assign rdata[0] = rom[rc[0]][rd[0]][ri[0]];
    assign rdata[1] = rom[rc[1]][rd[1]][ri[1]];

    sprite_line_renderer #(.SCALE_LOG2(0)) dut0 (
        .clk(clk), .reset(reset), .pix_en(pix_en), .pix_x(pix_x),
        .line_start(line_start), .line_y(line_y), .enable(enable),
        .sprite_x(sprite_x), .sprite_y(sprite_y), .charc(charc), .direction(direction),
        .rom_charc(rc[0]), .rom_direction(rd[0]), .rom_index(ri[0]),
        .rom_data(rdata[0]), .pixel_on(pon[0]), .busy(bsy[0])
    );

    sprite_line_renderer #(.SCALE_LOG2(1)) dut1 (
        .clk(clk), .reset(reset), .pix_en(pix_en), .pix_x(pix_x),
        .line_start(line_start), .line_y(line_y), .enable(enable),
        .sprite_x(sprite_x), .sprite_y(sprite_y), .charc(charc), .direction(direction),
        .rom_charc(rc[1]), .rom_direction(rd[1]), .rom_index(ri[1]),
        .rom_data(rdata[1]), .pixel_on(pon[1]), .busy(bsy[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic logic exp_pix(input int s, input int p);
        int k;
        k = p - m_sx[s];
        if (!m_inr[s]) return 1'b0;
        if (k < 0 || k >= (SPRITE_ROWS << s)) return 1'b0;
        return ~m_row[s][7 - (k >> s)];
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_inr[s] = 1'b0;
            m_idx[s] = '0;
            m_chr[s] = '0;
            m_dir[s] = '0;
        end
    endtask

    // Pulse line_start for line ly, update the model, check busy and ROM address.
    task automatic start_line(input int ly);
        int dy;
        line_y = 10'(ly);
        for (int s = 0; s < 2; s++) begin
            dy = ly - int'(sprite_y);
            m_inr[s] = enable && (dy >= 0) && ((dy >> s) < SPRITE_ROWS);
            if (m_inr[s]) begin
                m_idx[s] = 3'(dy >> s);
                m_chr[s] = charc;
                m_dir[s] = direction;
                m_sx[s]  = int'(sprite_x);
                m_row[s] = rom[charc][direction][dy >> s];
            end
        end
        pix_en     = 1'b0;
        line_start = 1'b1;
        step();
        line_start = 1'b0;
        for (int s = 0; s < 2; s++) begin
            check($sformatf("busy_after_line_start s%0d y%0d", s, ly), 32'(bsy[s]), 32'(m_inr[s]));
            check($sformatf("rom_index s%0d y%0d", s, ly), 32'(ri[s]), 32'(m_idx[s]));
            check($sformatf("rom_charc s%0d y%0d", s, ly), 32'(rc[s]), 32'(m_chr[s]));
            check($sformatf("rom_direction s%0d y%0d", s, ly), 32'(rd[s]), 32'(m_dir[s]));
        end
    endtask

    // Walk pix_x over [from,to]; with gap set, an idle cycle follows each pixel.
    task automatic sweep(input int from, input int to, input bit gap);
        for (int p = from; p <= to; p++) begin
            pix_x  = 10'(p);
            pix_en = 1'b1;
            step();
            for (int s = 0; s < 2; s++)
                check($sformatf("pixel_on s%0d x%0d", s, p), 32'(pon[s]), 32'(exp_pix(s, p)));
            if (gap) begin
                pix_en = 1'b0;
                step();
                for (int s = 0; s < 2; s++)
                    check($sformatf("pixel_hold s%0d x%0d", s, p), 32'(pon[s]), 32'(exp_pix(s, p)));
            end
        end
        pix_en = 1'b0;
    endtask

    task automatic full_line(input int ly, input bit gap);
        int sx;
        start_line(ly);
        wait_cycles(2);
        sx = int'(sprite_x);
        sweep(sx - 2, sx + 2 * SPRITE_ROWS + 1, gap);
        for (int s = 0; s < 2; s++)
            check($sformatf("busy_line_end s%0d y%0d", s, ly), 32'(bsy[s]), 32'd0);
    endtask

    initial begin
        for (int c = 0; c < 16; c++)
            for (int d = 0; d < 4; d++)
                for (int r = 0; r < 8; r++)
                    rom[c][d][r] = 8'($urandom);
        rom[HEART][UP][1] = 8'b10011001;

        reset      = 1'b0;
        pix_en     = 1'b0;
        pix_x      = '0;
        line_start = 1'b0;
        line_y     = '0;
        enable     = 1'b1;
        sprite_x   = 10'd200;
        sprite_y   = 10'd100;
        charc      = HEART;
        direction  = UP;
        model_reset();
        wait_cycles(2);

        // Reset state
        for (int s = 0; s < 2; s++) begin
            check($sformatf("rst_pixel_on s%0d", s), 32'(pon[s]), 32'd0);
            check($sformatf("rst_busy s%0d", s), 32'(bsy[s]), 32'd0);
            check($sformatf("rst_rom_index s%0d", s), 32'(ri[s]), 32'd0);
            check($sformatf("rst_rom_charc s%0d", s), 32'(rc[s]), 32'd0);
        end
        check("rst_row_buf s0", 32'(dut0.u_shifter.r_row_buf), 32'hFF);
        reset = 1'b1;
        wait_cycles(2);

        // Heart UP row 1 at 1x (line 101); 2x instance sees row 0 of the same sprite
        start_line(101);
        check("heart_rom_index s0", 32'(ri[0]), 32'd1);
        wait_cycles(2);
        check("heart_row_buf s0", 32'(dut0.u_shifter.r_row_buf), 32'h99);
        sweep(198, 217, 1'b0);
        check("heart_after_span s0", 32'(pon[0]), 32'd0);

        // Scaled: line 102 is row 1 at 2x
        start_line(102);
        check("scaled_rom_index s1", 32'(ri[1]), 32'd1);
        wait_cycles(2);
        check("scaled_row_buf s1", 32'(dut1.u_shifter.r_row_buf), 32'h99);
        sweep(198, 215, 1'b0);
        check("scaled_busy_after_215 s1", 32'(bsy[1]), 32'd0);
        sweep(216, 217, 1'b0);

        // Out of range above and below the 1x sprite
        full_line(99, 1'b0);
        full_line(108, 1'b0);
        check("oor_rom_index s0", 32'(ri[0]), 32'd2);

        // Snapshot: slot attributes change after LOAD, the line keeps the old ones
        start_line(101);
        wait_cycles(2);
        charc     = SWORD;
        direction = RIGHT;
        sweep(198, 217, 1'b0);
        check("snapshot_rom_charc s0", 32'(rc[0]), 32'(HEART));
        start_line(103);
        check("snapshot_next_charc s0", 32'(rc[0]), 32'(SWORD));
        wait_cycles(2);
        sweep(198, 217, 1'b0);
        charc     = HEART;
        direction = UP;

        // Abort mid-draw: new line_start on the pix_x 203 slot
        start_line(101);
        wait_cycles(2);
        sweep(198, 202, 1'b0);
        pix_x = 10'd203;
        start_line(104);
        pix_x  = 10'd204;
        pix_en = 1'b1;
        step();
        pix_en = 1'b0;
        for (int s = 0; s < 2; s++)
            check($sformatf("abort_pixel_cleared s%0d", s), 32'(pon[s]), 32'd0);
        wait_cycles(1);
        sweep(198, 217, 1'b0);

        // pix_en every second clock
        full_line(101, 1'b1);
        full_line(100, 1'b1);

        // Asynchronous reset while drawing
        start_line(101);
        wait_cycles(2);
        sweep(198, 201, 1'b0);
        check("pre_reset_pixel_on s0", 32'(pon[0]), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        for (int s = 0; s < 2; s++) begin
            check($sformatf("async_rst_pixel_on s%0d", s), 32'(pon[s]), 32'd0);
            check($sformatf("async_rst_busy s%0d", s), 32'(bsy[s]), 32'd0);
            check($sformatf("async_rst_rom_index s%0d", s), 32'(ri[s]), 32'd0);
            check($sformatf("async_rst_rom_charc s%0d", s), 32'(rc[s]), 32'd0);
            check($sformatf("async_rst_rom_dir s%0d", s), 32'(rd[s]), 32'd0);
        end
        check("async_rst_row_buf s1", 32'(dut1.u_shifter.r_row_buf), 32'hFF);
        wait_cycles(2);
        reset = 1'b1;
        sweep(200, 205, 1'b0);
        full_line(101, 1'b0);

        // Randomised slots and lines
        for (int n = 0; n < 24; n++) begin
            sprite_y  = 10'($urandom_range(3, 900));
            sprite_x  = 10'($urandom_range(2, 600));
            enable    = ($urandom_range(0, 7) != 0);
            charc     = 4'($urandom_range(0, 15));
            direction = 2'($urandom_range(0, 3));
            full_line(int'(sprite_y) - 3 + int'($urandom_range(0, 22)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
